// File: rtl/sync_fifo_lvl.sv
// Synchronous FIFO with arbitrary depth, an occupancy count, almost-full/almost-empty flags and sticky error flags.
// Define SYNC_FIFO_LVL_FWFT_EN for first-word-fall-through reads; the default build gives registered reads with one cycle of latency.
module sync_fifo_lvl #(
    parameter int unsigned DataWidth = 64,
    parameter int unsigned Depth     = 16,
    parameter int unsigned AFullThr  = Depth - 2,
    parameter int unsigned AEmptyThr = 2,
    localparam int unsigned CntW     = $clog2(Depth + 1)
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic [DataWidth-1:0] WData,
    input  logic                 WInc,
    output logic                 WFull,
    input  logic                 RInc,
    output logic [DataWidth-1:0] RData,
    output logic                 REmpty,
    output logic                 AlmostFull,
    output logic                 AlmostEmpty,
    output logic [CntW-1:0]      Count,
    output logic                 Overflow,
    output logic                 Underflow
);

    localparam int unsigned PtrW = $clog2(Depth);

    // Pointers wrap explicitly at Depth-1 because Depth need not be a power of two.
    function automatic logic [PtrW-1:0] ptr_next(input logic [PtrW-1:0] ptr);
        logic [PtrW-1:0] nxt;
        if (ptr == PtrW'(Depth - 1)) begin
            nxt = '0;
        end else begin
            nxt = ptr + PtrW'(1);
        end
        return nxt;
    endfunction

    logic [DataWidth-1:0] mem_q [Depth];
    logic [PtrW-1:0]      wptr_q, wptr_d;
    logic [PtrW-1:0]      rptr_q, rptr_d;
    logic [CntW-1:0]      count_q, count_d;
    logic [DataWidth-1:0] rdata_q, rdata_d;
    logic                 ovf_q, ovf_d;
    logic                 unf_q, unf_d;
    logic                 full_s, empty_s, wr_acc_s, rd_acc_s, wr_mem_s;
`ifdef SYNC_FIFO_LVL_FWFT_EN
    logic                 ovalid_q, ovalid_d;
    logic                 mem_empty_s;
`endif

    // Next-state decode: accept/reject, count, pointers and output register.
    always_comb begin
        full_s   = (count_q == CntW'(Depth));
`ifdef SYNC_FIFO_LVL_FWFT_EN
        empty_s  = !ovalid_q;
`else
        empty_s  = (count_q == CntW'(0));
`endif
        wr_acc_s = WInc && !full_s;
        rd_acc_s = RInc && !empty_s;
        ovf_d    = ovf_q || (WInc && full_s);
        unf_d    = unf_q || (RInc && empty_s);
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        rdata_d  = rdata_q;
        wr_mem_s = 1'b0;
        case ({wr_acc_s, rd_acc_s})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
`ifdef SYNC_FIFO_LVL_FWFT_EN
        // The output register counts as one stored word; the array holds the rest.
        mem_empty_s = ((count_q - CntW'(ovalid_q)) == CntW'(0));
        ovalid_d    = ovalid_q;
        if (!ovalid_q || rd_acc_s) begin
            if (!mem_empty_s) begin
                rdata_d  = mem_q[rptr_q];
                rptr_d   = ptr_next(rptr_q);
                ovalid_d = 1'b1;
                wr_mem_s = wr_acc_s;
            end else if (wr_acc_s) begin
                rdata_d  = WData;
                ovalid_d = 1'b1;
            end else begin
                ovalid_d = 1'b0;
            end
        end else begin
            wr_mem_s = wr_acc_s;
        end
`else
        wr_mem_s = wr_acc_s;
        if (rd_acc_s) begin
            rdata_d = mem_q[rptr_q];
            rptr_d  = ptr_next(rptr_q);
        end else begin
            rdata_d = rdata_q;
        end
`endif
        if (wr_mem_s) begin
            wptr_d = ptr_next(wptr_q);
        end else begin
            wptr_d = wptr_q;
        end
    end

    // Control state with synchronous reset; a reset cycle ignores WInc/RInc.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            rdata_q  <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
`ifdef SYNC_FIFO_LVL_FWFT_EN
            ovalid_q <= 1'b0;
`endif
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            rdata_q  <= rdata_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
`ifdef SYNC_FIFO_LVL_FWFT_EN
            ovalid_q <= ovalid_d;
`endif
        end
    end

    // Storage array, deliberately not reset.
    always_ff @(posedge Clk) begin
        if (wr_mem_s && !Rst) begin
            mem_q[wptr_q] <= WData;
        end
    end

    assign WFull       = full_s;
    assign REmpty      = empty_s;
    assign AlmostFull  = (32'(count_q) >= 32'(AFullThr));
    assign AlmostEmpty = (32'(count_q) <= 32'(AEmptyThr));
    assign Count       = count_q;
    assign RData       = rdata_q;
    assign Overflow    = ovf_q;
    assign Underflow   = unf_q;

endmodule

// File: tb/tb_sync_fifo_lvl.sv
// Directed self-checking bench for sync_fifo_lvl with Depth=5, AFullThr=3, AEmptyThr=1.
module tb_sync_fifo_lvl;

    localparam int DW = 8;
    localparam int CW = 3;

    logic          Clk = 1'b0;
    logic          Rst, WInc, RInc;
    logic [DW-1:0] WData, RData;
    logic          WFull, REmpty, AlmostFull, AlmostEmpty, Overflow, Underflow;
    logic [CW-1:0] Count;
    int            total = 0;
    int            bad   = 0;

    sync_fifo_lvl #(.DataWidth(DW), .Depth(5), .AFullThr(3), .AEmptyThr(1)) dut (
        .Clk(Clk), .Rst(Rst), .WData(WData), .WInc(WInc), .WFull(WFull),
        .RInc(RInc), .RData(RData), .REmpty(REmpty), .AlmostFull(AlmostFull),
        .AlmostEmpty(AlmostEmpty), .Count(Count), .Overflow(Overflow), .Underflow(Underflow)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk_lvl(input string tag, input int n);
        chk({tag, ".count"}, 64'(Count), 64'(n));
        chk({tag, ".afull"}, 64'(AlmostFull), 64'(n >= 3));
        chk({tag, ".aempty"}, 64'(AlmostEmpty), 64'(n <= 1));
        chk({tag, ".full"}, 64'(WFull), 64'(n == 5));
    endtask

    task automatic chk_reset_state(input string tag);
        chk_lvl(tag, 0);
        chk({tag, ".empty"}, 64'(REmpty), 64'd1);
        chk({tag, ".rdata"}, 64'(RData), 64'd0);
        chk({tag, ".ovf"}, 64'(Overflow), 64'd0);
        chk({tag, ".unf"}, 64'(Underflow), 64'd0);
    endtask

    initial begin
        Rst = 1'b1; WInc = 1'b0; RInc = 1'b0; WData = 8'h00;
        step(); step();
        Rst = 1'b0;
        chk_reset_state("reset");

`ifdef SYNC_FIFO_LVL_FWFT_EN
        WInc = 1'b1; WData = 8'h01;
        step();
        WInc = 1'b0;
        chk("fwft.first.empty", 64'(REmpty), 64'd0);
        chk("fwft.first.rdata", 64'(RData), 64'h01);
        chk_lvl("fwft.first", 1);
        step();
        chk("fwft.hold.rdata", 64'(RData), 64'h01);
        for (int i = 2; i <= 5; i++) begin
            WInc = 1'b1; WData = 8'(i);
            step();
            chk_lvl("fwft.fill", i);
            chk("fwft.fill.rdata", 64'(RData), 64'h01);
        end
        WInc = 1'b1; RInc = 1'b1; WData = 8'hAA;
        step();
        WInc = 1'b0;
        chk_lvl("fwft.fullrw", 4);
        chk("fwft.fullrw.ovf", 64'(Overflow), 64'd1);
        chk("fwft.fullrw.rdata", 64'(RData), 64'h02);
        for (int i = 3; i <= 5; i++) begin
            step();
            chk("fwft.pop.rdata", 64'(RData), 64'(i));
            chk_lvl("fwft.pop", 6 - i);
        end
        step();
        RInc = 1'b0;
        chk("fwft.drained.empty", 64'(REmpty), 64'd1);
        chk_lvl("fwft.drained", 0);
        chk("fwft.drained.unf", 64'(Underflow), 64'd0);
        RInc = 1'b1;
        step();
        RInc = 1'b0;
        chk("fwft.under.unf", 64'(Underflow), 64'd1);
        chk("fwft.under.rdata", 64'(RData), 64'h05);
        for (int i = 0; i < 3; i++) begin
            WInc = 1'b1; WData = 8'h30 + 8'(i);
            step();
        end
        chk_lvl("fwft.three", 3);
        Rst = 1'b1; WInc = 1'b1; RInc = 1'b1;
        step();
        Rst = 1'b0; WInc = 1'b0; RInc = 1'b0;
        chk_reset_state("fwft.midrst");
`else
        for (int i = 1; i <= 5; i++) begin
            WInc = 1'b1; WData = 8'(i * 17);
            step();
            chk_lvl("fill", i);
            chk("fill.empty", 64'(REmpty), 64'd0);
        end
        WInc = 1'b1; RInc = 1'b1; WData = 8'hAA;
        step();
        WInc = 1'b0;
        chk_lvl("fullrw", 4);
        chk("fullrw.ovf", 64'(Overflow), 64'd1);
        chk("fullrw.unf", 64'(Underflow), 64'd0);
        chk("fullrw.rdata", 64'(RData), 64'h11);
        for (int i = 2; i <= 5; i++) begin
            step();
            chk("drain.rdata", 64'(RData), 64'(i * 17));
            chk_lvl("drain", 5 - i);
        end
        chk("drain.empty", 64'(REmpty), 64'd1);
        step();
        RInc = 1'b0;
        chk("under.unf", 64'(Underflow), 64'd1);
        chk("under.rdata", 64'(RData), 64'h55);
        chk_lvl("under", 0);
        WInc = 1'b1; RInc = 1'b1; WData = 8'hBB;
        step();
        WInc = 1'b0;
        chk_lvl("emptyrw", 1);
        chk("emptyrw.rdata", 64'(RData), 64'h55);
        step();
        RInc = 1'b0;
        chk("emptyrw.read", 64'(RData), 64'hBB);
        chk_lvl("emptyrw.after", 0);
        for (int k = 0; k < 13; k++) begin
            WInc = 1'b1; WData = 8'h60 + 8'(k);
            step();
            WInc = 1'b0;
            chk_lvl("wrap.w", 1);
            RInc = 1'b1;
            step();
            RInc = 1'b0;
            chk("wrap.rdata", 64'(RData), 64'(8'h60 + 8'(k)));
            chk_lvl("wrap.r", 0);
        end
        for (int i = 0; i < 3; i++) begin
            WInc = 1'b1; WData = 8'h30 + 8'(i);
            step();
        end
        WInc = 1'b0; RInc = 1'b1;
        step();
        chk("pre.rst.rdata", 64'(RData), 64'h30);
        Rst = 1'b1; WInc = 1'b1; RInc = 1'b1;
        step();
        Rst = 1'b0; WInc = 1'b0; RInc = 1'b0;
        chk_reset_state("midrst");
        WInc = 1'b1; WData = 8'hC3;
        step();
        WInc = 1'b0; RInc = 1'b1;
        step();
        RInc = 1'b0;
        chk("postrst.rdata", 64'(RData), 64'hC3);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
